uart_cmd_parser: RTL and testbench

Downstream consumer of the UART byte receiver in the spiadc design. Takes the receiver's one-cycle byte strobe and data byte, assembles fixed 6-byte command frames, and checks sync and XOR checksum. Presents each validated command to the SPI ADC control logic over a valid/ready handshake. Flags checksum, inter-byte timeout and overrun errors with single-cycle pulses.

---
 rtl/spiadc_pkg.sv | 30 +++
 rtl/uart_cmd_parser_if.sv | 27 ++
 rtl/uart_gap_timer.sv | 32 +++
 rtl/uart_cmd_parser.sv | 110 +++++++++++
 tb/tb_uart_cmd_parser.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spiadc_pkg.sv
// Shared definitions for the spiadc command path.
// Parser state encoding, frame constants and ADC opcodes.
package spiadc_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OP   = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DH   = 3'd3;
    localparam logic [2:0] ST_DL   = 3'd4;
    localparam logic [2:0] ST_CHK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_OP   = ST_OP,
        S_ADDR = ST_ADDR,
        S_DH   = ST_DH,
        S_DL   = ST_DL,
        S_CHK  = ST_CHK
    } parse_state_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_RD_REG = 8'h01;
    localparam logic [7:0] OP_WR_REG = 8'h02;
    localparam logic [7:0] OP_SAMPLE = 8'h03;
    localparam logic [7:0] OP_STREAM = 8'h04;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Command handshake bundle between parser and ADC controller.
// master drives the command, slave returns ready.
interface uart_cmd_parser_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter; expire fires on the cycle the
// count steps onto TIMEOUT-1 with no clear pending.
module uart_gap_timer #(
    parameter int TIMEOUT = 50000,
    localparam int W = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] PRE  = W'(TIMEOUT - 2);

    logic [W-1:0] cnt;

    // Count idle cycles while enabled, saturating at TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && !clr && (cnt == PRE);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte UART command frames, checks sync/XOR and
// hands validated commands downstream over valid/ready.
module uart_cmd_parser
    import spiadc_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        din,
    uart_cmd_parser_if.master cmd,
    output logic              err_chk,
    output logic              err_timeout,
    output logic              err_overrun
);

    parse_state_t state;
    logic [7:0]   op_q;
    logic [7:0]   addr_q;
    logic [7:0]   dh_q;
    logic [7:0]   dl_q;
    logic [7:0]   xor_q;
    logic         gap_expire;

    uart_gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap (
        .clk   (clk),
        .reset (reset),
        .clr   (rx_done_tick || state == S_IDLE),
        .en    (state != S_IDLE),
        .expire(gap_expire)
    );

    // Frame FSM, output latch and registered error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            dh_q          <= '0;
            dl_q          <= '0;
            xor_q         <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_op    <= '0;
            cmd.cmd_addr  <= '0;
            cmd.cmd_data  <= '0;
            err_chk       <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            if (cmd.cmd_valid && cmd.cmd_ready) begin
                cmd.cmd_valid <= 1'b0;
            end
            if (rx_done_tick) begin
                unique case (state)
                    S_IDLE: begin
                        if (din == SYNC_BYTE) begin
                            state <= S_OP;
                            xor_q <= '0;
                        end
                    end
                    S_OP: begin
                        op_q  <= din;
                        xor_q <= xor_q ^ din;
                        state <= S_ADDR;
                    end
                    S_ADDR: begin
                        addr_q <= din;
                        xor_q  <= xor_q ^ din;
                        state  <= S_DH;
                    end
                    S_DH: begin
                        dh_q  <= din;
                        xor_q <= xor_q ^ din;
                        state <= S_DL;
                    end
                    S_DL: begin
                        dl_q  <= din;
                        xor_q <= xor_q ^ din;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        state <= S_IDLE;
                        if (din != xor_q) begin
                            err_chk <= 1'b1;
                        end else if (!cmd.cmd_valid || cmd.cmd_ready) begin
                            cmd.cmd_valid <= 1'b1;
                            cmd.cmd_op    <= op_q;
                            cmd.cmd_addr  <= addr_q;
                            cmd.cmd_data  <= {dh_q, dl_q};
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (gap_expire) begin
                state       <= S_IDLE;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with TIMEOUT=16.
// Driver pushes expectations; negedge monitor pops and compares.
module tb_uart_cmd_parser;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       err_chk;
    logic       err_timeout;
    logic       err_overrun;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .din         (din),
        .cmd         (bus),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_cmd_t;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } exp_err_t;

    localparam logic [2:0] K_CHK = 3'b100;
    localparam logic [2:0] K_TO  = 3'b010;
    localparam logic [2:0] K_OVR = 3'b001;

    exp_cmd_t cq[$];
    exp_err_t eq[$];
    int checks = 0;
    int errors = 0;

    bit          fresh = 1'b1;
    logic [7:0]  h_op;
    logic [7:0]  h_addr;
    logic [15:0] h_data;
    exp_cmd_t    ec;
    exp_err_t    ee;
    logic [2:0]  ek;

    // Monitor: pop on each newly loaded command and each error pulse.
    always @(negedge clk) begin
        if (!reset) begin
            fresh = 1'b1;
        end else begin
            if (bus.cmd_valid) begin
                checks++;
                if (fresh) begin
                    if (cq.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected cyc=%0d op=%h addr=%h data=%h",
                                 cyc, bus.cmd_op, bus.cmd_addr, bus.cmd_data);
                    end else begin
                        ec = cq.pop_front();
                        if (bus.cmd_op != ec.op || bus.cmd_addr != ec.addr ||
                            bus.cmd_data != ec.data || cyc != ec.cyc) begin
                            errors++;
                            $display("FAIL cmd got op=%h addr=%h data=%h cyc=%0d want op=%h addr=%h data=%h cyc=%0d",
                                     bus.cmd_op, bus.cmd_addr, bus.cmd_data, cyc,
                                     ec.op, ec.addr, ec.data, ec.cyc);
                        end
                    end
                    h_op   = bus.cmd_op;
                    h_addr = bus.cmd_addr;
                    h_data = bus.cmd_data;
                    fresh  = 1'b0;
                end else if (bus.cmd_op != h_op || bus.cmd_addr != h_addr ||
                             bus.cmd_data != h_data) begin
                    errors++;
                    $display("FAIL cmd_stable cyc=%0d got %h/%h/%h want %h/%h/%h",
                             cyc, bus.cmd_op, bus.cmd_addr, bus.cmd_data,
                             h_op, h_addr, h_data);
                end
                if (bus.cmd_ready) fresh = 1'b1;
            end
            ek = {err_chk, err_timeout, err_overrun};
            if (ek != 3'b000) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected cyc=%0d got %b", cyc, ek);
                end else begin
                    ee = eq.pop_front();
                    if (ek != ee.kind || cyc != ee.cyc) begin
                        errors++;
                        $display("FAIL err got %b cyc=%0d want %b cyc=%0d",
                                 ek, cyc, ee.kind, ee.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic rdy = 1'b0);
        rx_done_tick  = 1'b1;
        din           = b;
        bus.cmd_ready = rdy;
        @(posedge clk);
        #1;
        rx_done_tick  = 1'b0;
        din           = 8'h00;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [7:0] addr,
                            input logic [15:0] data);
        exp_cmd_t e;
        e.op   = op;
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc + 1;
        cq.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] kind, input int lat);
        exp_err_t e;
        e.kind = kind;
        e.cyc  = cyc + lat;
        eq.push_back(e);
    endtask

    // kind==0: good frame expected to load; otherwise the error it raises.
    task automatic frame(input logic [7:0] op, input logic [7:0] addr,
                         input logic [7:0] dh, input logic [7:0] dl,
                         input logic [7:0] chk, input logic [2:0] kind,
                         input logic rdy);
        send(8'hA5);
        send(op);
        send(addr);
        send(dh);
        send(dl);
        if (kind == 3'b000) push_cmd(op, addr, {dh, dl});
        else push_err(kind, 1);
        send(chk, rdy);
    endtask

    task automatic check_zero(input string name);
        logic [36:0] v;
        v = {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data,
             err_chk, err_timeout, err_overrun};
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s got %h want 0", name, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b1;
        gap(2);

        frame(8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 3'b000, 1'b0);
        gap(3);
        accept();
        gap(2);

        frame(8'h01, 8'h02, 8'h12, 8'h34, 8'h26, K_CHK, 1'b0);
        gap(3);
        frame(8'h0A, 8'h0B, 8'hCD, 8'hEF, 8'h23, 3'b000, 1'b0);
        gap(2);
        accept();
        gap(2);

        send(8'h00);
        send(8'hFF);
        frame(8'h03, 8'h04, 8'h00, 8'h10, 8'h17, 3'b000, 1'b0);
        gap(2);
        accept();
        gap(2);

        send(8'hA5);
        push_err(K_TO, TO);
        send(8'h01);
        gap(20);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        send(8'h25);
        gap(3);

        frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 3'b000, 1'b0);
        gap(1);
        accept();
        gap(2);

        frame(8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 3'b000, 1'b0);
        gap(2);
        frame(8'h03, 8'h04, 8'h00, 8'h10, 8'h17, K_OVR, 1'b0);
        gap(3);
        frame(8'h03, 8'h04, 8'h00, 8'h10, 8'h17, 3'b000, 1'b1);
        gap(2);
        accept();
        gap(2);

        send(8'hA5);
        send(8'h01);
        send(8'h02);
        reset = 1'b0;
        gap(1);
        check_zero("reset_midframe");
        reset = 1'b1;
        send(8'h12);
        send(8'h34);
        send(8'h25);
        gap(2);
        frame(8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 3'b000, 1'b0);
        gap(2);
        reset = 1'b0;
        gap(1);
        check_zero("reset_pending");
        reset = 1'b1;
        gap(1);
        frame(8'h0A, 8'h0B, 8'hCD, 8'hEF, 8'h23, 3'b000, 1'b0);
        gap(2);
        accept();
        gap(5);

        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL cmd_missing got %0d left want 0", cq.size());
        end
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL err_missing got %0d left want 0", eq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
